// File: rtl/snax_tcdm_rr_arbiter.sv
// snax_tcdm_rr_arbiter
// Shares one TCDM reqrsp port between NumReq requesters. The request (q)
// channel is granted round-robin and the grant is held until its handshake.
// An in-order ID FIFO remembers which requester issued each accepted request,
// so each response (p) is steered back to that requester.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_*_i / req_ready_o    per-requester q channel (flattened, k-th slice per requester)
//   rsp_valid_o, rsp_data_o  one-hot p valid to the owner, broadcast p data
//   mem_q_* / mem_p_*        shared TCDM port
//   outstanding_o            accepted-but-unanswered request count
//   err_o                    sticky: response arrived with nothing outstanding
//
// State | meaning
// IDLE   | no grant held; arbitrate among valid requesters when FIFO not full
// LOCKED | requester gnt_q owns the TCDM q channel until its handshake
module snax_tcdm_rr_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned IdW           = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntW          = $clog2(MaxOutstanding) + 1,
    localparam int unsigned PtrW          = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_write_i,
    input  logic [NumReq*DataWidth-1:0]     req_data_i,
    input  logic [NumReq*StrbWidth-1:0]     req_strb_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [DataWidth-1:0]            rsp_data_o,
    output logic                            mem_q_valid_o,
    input  logic                            mem_q_ready_i,
    output logic [AddrWidth-1:0]            mem_q_addr_o,
    output logic                            mem_q_write_o,
    output logic [DataWidth-1:0]            mem_q_data_o,
    output logic [StrbWidth-1:0]            mem_q_strb_o,
    input  logic                            mem_p_valid_i,
    input  logic [DataWidth-1:0]            mem_p_data_i,
    output logic [CntW-1:0]                 outstanding_o,
    output logic                            err_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      gnt_q, gnt_d;
    logic [IdW-1:0]      rr_q, rr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PtrW-1:0]     wr_q, rd_q;
    logic [IdW-1:0]      id_fifo_q [MaxOutstanding];
    logic                err_q;

    logic                fifo_full, fifo_empty, push, pop;
    logic                pick_found;
    logic [IdW-1:0]      pick_idx;
    logic [IdW:0]        pick_sum;
    logic [2*NumReq-1:0] valid_dbl;
    logic [NumReq-1:0]   valid_rot;

    logic [AddrWidth-1:0] addr_s [NumReq];
    logic [DataWidth-1:0] data_s [NumReq];
    logic [StrbWidth-1:0] strb_s [NumReq];

    for (genvar k = 0; k < NumReq; k++) begin : g_slice
        assign addr_s[k] = req_addr_i[k*AddrWidth +: AddrWidth];
        assign data_s[k] = req_data_i[k*DataWidth +: DataWidth];
        assign strb_s[k] = req_strb_i[k*StrbWidth +: StrbWidth];
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    // A response needs an ID that was already registered; a same-cycle push cannot serve it.
    assign pop        = mem_p_valid_i && !fifo_empty;

    // Rotate valids so the pointer lands on bit 0; the first set bit is the
    // circular distance from the pointer, then fold the sum back into range.
    always_comb begin
        valid_dbl  = {req_valid_i, req_valid_i} >> rr_q;
        valid_rot  = valid_dbl[NumReq-1:0];
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!pick_found && valid_rot[j]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_q} + (IdW+1)'(j);
            end
        end
        if (pick_sum >= (IdW+1)'(NumReq)) begin
            pick_sum = pick_sum - (IdW+1)'(NumReq);
        end
        pick_idx = pick_sum[IdW-1:0];
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_d          = rr_q;
        push          = 1'b0;
        req_ready_o   = '0;
        mem_q_valid_o = 1'b0;
        mem_q_addr_o  = '0;
        mem_q_write_o = 1'b0;
        mem_q_data_o  = '0;
        mem_q_strb_o  = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_full && pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                mem_q_valid_o      = req_valid_i[gnt_q];
                mem_q_addr_o       = addr_s[gnt_q];
                mem_q_write_o      = req_write_i[gnt_q];
                mem_q_data_o       = data_s[gnt_q];
                mem_q_strb_o       = strb_s[gnt_q];
                req_ready_o[gnt_q] = mem_q_ready_i;
                if (req_valid_i[gnt_q] && mem_q_ready_i) begin
                    push    = 1'b1;
                    rr_d    = (gnt_q == IdW'(NumReq - 1)) ? '0 : gnt_q + IdW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        if (pop) begin
            rsp_valid_o[id_fifo_q[rd_q]] = 1'b1;
            rsp_data_o                   = mem_p_data_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            if (mem_p_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    // ID storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) id_fifo_q[wr_q] <= gnt_q;
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_snax_tcdm_rr_arbiter.sv
module tb_snax_tcdm_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int MO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N-1:0]    req_write_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N*SW-1:0] req_strb_i = '0;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_data_o;
    logic            mem_q_valid_o;
    logic            mem_q_ready_i = 1'b0;
    logic [AW-1:0]   mem_q_addr_o;
    logic            mem_q_write_o;
    logic [DW-1:0]   mem_q_data_o;
    logic [SW-1:0]   mem_q_strb_o;
    logic            mem_p_valid_i = 1'b0;
    logic [DW-1:0]   mem_p_data_i = '0;
    logic [3:0]      outstanding_o;
    logic            err_o;

    snax_tcdm_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_data_i(req_data_i), .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .mem_q_valid_o(mem_q_valid_o), .mem_q_ready_i(mem_q_ready_i), .mem_q_addr_o(mem_q_addr_o),
        .mem_q_write_o(mem_q_write_o), .mem_q_data_o(mem_q_data_o), .mem_q_strb_o(mem_q_strb_o),
        .mem_p_valid_i(mem_p_valid_i), .mem_p_data_i(mem_p_data_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus knobs
    bit           drive_en = 1'b0;
    bit           p_en     = 1'b1;
    bit           manual_p = 1'b0;
    logic [N-1:0] mask     = '1;
    int           req_pct  = 100;
    int           rdy_pct  = 100;
    int           p_dmax   = 0;
    int           cyc      = 0;

    // per-requester outstanding request
    logic [AW-1:0] r_addr [N];
    bit            r_wr   [N];
    logic [DW-1:0] r_data [N];
    logic [SW-1:0] r_strb [N];
    bit            active [N];
    bit            done   [N];

    typedef struct {logic [DW-1:0] data; int due;} pend_t;
    typedef struct {logic [N-1:0] oh; logic [DW-1:0] data;} exp_t;
    pend_t pend[$];
    exp_t  expq[$];
    int    gnt_log[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    // driver: all inputs change 1 time unit after the rising edge
    always @(posedge clk_i) begin
        #1;
        cyc++;
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                active[k] = 1'b0;
                done[k]   = 1'b0;
            end
            pend.delete();
            req_valid_i   = '0;
            mem_q_ready_i = 1'b0;
            mem_p_valid_i = 1'b0;
            mem_p_data_i  = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (done[k]) begin
                    active[k] = 1'b0;
                    done[k]   = 1'b0;
                end
                if (!active[k] && drive_en && mask[k] && $urandom_range(0, 99) < req_pct) begin
                    active[k] = 1'b1;
                    r_addr[k] = AW'({$urandom_range(0, 15), 3'b000});
                    r_wr[k]   = ($urandom_range(0, 1) == 1);
                    r_data[k] = {$urandom, $urandom};
                    r_strb[k] = SW'($urandom);
                    req_addr_i[k*AW +: AW] = r_addr[k];
                    req_write_i[k]         = r_wr[k];
                    req_data_i[k*DW +: DW] = r_data[k];
                    req_strb_i[k*SW +: SW] = r_strb[k];
                end
                req_valid_i[k] = active[k];
            end
            mem_q_ready_i = ($urandom_range(0, 99) < rdy_pct);
            mem_p_valid_i = 1'b0;
            mem_p_data_i  = '0;
            if (manual_p) begin
                mem_p_valid_i = 1'b1;
                mem_p_data_i  = 64'hDEAD_BEEF;
                manual_p      = 1'b0;
            end else if (p_en && pend.size() > 0 && pend[0].due <= cyc) begin
                mem_p_valid_i = 1'b1;
                mem_p_data_i  = pend[0].data;
                void'(pend.pop_front());
            end
        end
    end

    // Reference model of the q side: a grant is "in flight" from the cycle the
    // arbiter picks until its handshake; the pick is the first valid requester
    // at or after the priority pointer, and only when fewer than MO are owed.
    bit            locked = 1'b0;
    int            g = 0, ptr = 0, occ = 0, idx = 0;
    bit            found, inc;
    logic [AW-1:0] a;
    logic [DW-1:0] rdata, old;

    always @(negedge clk_i) begin
        if (rst_i) begin
            locked = 1'b0;
            ptr    = 0;
            occ    = 0;
            expq.delete();
        end else begin
            inc = 1'b0;
            chk("outstanding", 64'(outstanding_o), 64'(occ));
            if (locked) begin
                chk("q_valid", 64'(mem_q_valid_o), 64'd1);
                chk("q_ready_onehot", 64'(req_ready_o), mem_q_ready_i ? 64'(4'b0001 << g) : 64'd0);
                chk("q_addr", 64'(mem_q_addr_o), 64'(r_addr[g]));
                chk("q_write", 64'(mem_q_write_o), 64'(r_wr[g]));
                chk("q_data", mem_q_data_o, r_data[g]);
                chk("q_strb", 64'(mem_q_strb_o), 64'(r_strb[g]));
                if (mem_q_ready_i) begin
                    a   = r_addr[g];
                    old = mem.exists(a) ? mem[a] : {16'hA5A5, a};
                    if (r_wr[g]) begin
                        for (int b = 0; b < SW; b++)
                            if (r_strb[g][b]) old[b*8 +: 8] = r_data[g][b*8 +: 8];
                        mem[a] = old;
                        rdata  = {$urandom, $urandom};
                    end else begin
                        rdata = old;
                    end
                    pend.push_back('{rdata, cyc + 1 + int'($urandom_range(0, p_dmax))});
                    expq.push_back('{N'(1) << g, rdata});
                    done[g] = 1'b1;
                    gnt_log.push_back(g);
                    ptr    = (g + 1) % N;
                    locked = 1'b0;
                    inc    = 1'b1;
                end
            end else begin
                chk("q_idle_valid", 64'(mem_q_valid_o), 64'd0);
                chk("q_idle_ready", 64'(req_ready_o), 64'd0);
                if (occ < MO && req_valid_i != '0) begin
                    found = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        idx = (ptr + i) % N;
                        if (!found && req_valid_i[idx[1:0]]) begin
                            found = 1'b1;
                            g     = idx;
                        end
                    end
                    locked = 1'b1;
                end
            end
            if (mem_p_valid_i && occ > 0) occ--;
            if (inc) occ++;
        end
    end

    // response monitor: every p is matched against the issue-order scoreboard
    exp_t e;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mem_p_valid_i) begin
                if (expq.size() == 0) begin
                    chk("rsp_orphan", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_owner", 64'(rsp_valid_o), 64'(e.oh));
                    chk("rsp_data", rsp_data_o, e.data);
                end
            end else begin
                chk("rsp_quiet", 64'(rsp_valid_o), 64'd0);
            end
        end
    end

    function automatic bit any_active();
        bit r = 1'b0;
        for (int k = 0; k < N; k++) r |= active[k];
        return r;
    endfunction

    task automatic drain();
        drive_en = 1'b0;
        p_en     = 1'b1;
        for (int i = 0; i < 1000 && (expq.size() != 0 || any_active()); i++) @(negedge clk_i);
        chk("drain_scoreboard", 64'(expq.size()), 64'd0);
        @(negedge clk_i);
        chk("drain_outstanding", 64'(outstanding_o), 64'd0);
    endtask

    task automatic wait_occ(input int target);
        for (int i = 0; i < 200 && outstanding_o != 4'(target); i++) @(negedge clk_i);
        chk("reach_outstanding", 64'(outstanding_o), 64'(target));
    endtask

    task automatic pulse_reset();
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_q_valid", 64'(mem_q_valid_o), 64'd0);
        chk("rst_q_addr", 64'(mem_q_addr_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_req_ready", 64'(req_ready_o), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_q_valid", 64'(mem_q_valid_o), 64'd0);
        chk("reset_outstanding", 64'(outstanding_o), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;

        // all four requesting, TCDM always ready: rotation 0,1,2,3,0
        mask = '1; req_pct = 100; rdy_pct = 100; p_dmax = 1;
        gnt_log.delete();
        drive_en = 1'b1;
        for (int i = 0; i < 60 && gnt_log.size() < 5; i++) @(negedge clk_i);
        chk("rotation_len", 64'(gnt_log.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++) chk("rotation_order", 64'(gnt_log[i]), 64'(i % N));
        drain();

        // req0 streaming with no responses: stall at full, resume after pops
        mask = 4'b0001; p_en = 1'b0; rdy_pct = 100; p_dmax = 0;
        drive_en = 1'b1;
        wait_occ(MO);
        repeat (4) begin
            @(negedge clk_i);
            chk("full_req_ready", 64'(req_ready_o), 64'd0);
            chk("full_q_valid", 64'(mem_q_valid_o), 64'd0);
        end
        drain();

        // reset while a grant is stalled with responses owed
        mask = 4'b0001; p_en = 1'b0; rdy_pct = 100;
        drive_en = 1'b1;
        wait_occ(3);
        rdy_pct = 0;
        repeat (3) @(negedge clk_i);
        chk("stall_q_valid", 64'(mem_q_valid_o), 64'd1);
        chk("stall_outstanding", 64'(outstanding_o == 4'd3 || outstanding_o == 4'd4), 64'd1);
        drive_en = 1'b0;
        pulse_reset();

        // late response with nothing owed: sticky error, no p to anyone
        manual_p = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("err_set", 64'(err_o), 64'd1);
        repeat (5) @(negedge clk_i);
        chk("err_sticky", 64'(err_o), 64'd1);
        pulse_reset();

        // pointer restarts at requester 0 after reset
        mask = '1; req_pct = 100; rdy_pct = 100; p_en = 1'b1;
        gnt_log.delete();
        drive_en = 1'b1;
        for (int i = 0; i < 20 && gnt_log.size() < 1; i++) @(negedge clk_i);
        chk("ptr_restart", 64'(gnt_log.size() >= 1 ? gnt_log[0] : 99), 64'd0);
        drain();

        // randomized traffic
        mask = '1; req_pct = 40; rdy_pct = 70; p_dmax = 3;
        drive_en = 1'b1;
        repeat (3000) @(negedge clk_i);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
